// File: rtl/ibex_ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-enable to HSIZE/offset decoder
// used by the Ibex dual-port AHB master bridge.
package ibex_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [3:0] HPROT_FETCH = 4'b0010;
    localparam logic [3:0] HPROT_DATA  = 4'b0011;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    typedef struct packed {
        logic [2:0] size;
        logic [2:0] offset;
    } size_off_t;

    // Naturally aligned byte/half/word lanes map to a narrower transfer;
    // anything irregular falls back to a full-width access at offset 0.
    function automatic size_off_t be_to_size(input logic [7:0] be, input int nbytes);
        size_off_t r;
        r.size   = (nbytes == 8) ? HSIZE_DWORD : HSIZE_WORD;
        r.offset = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (k < nbytes && be == (8'h01 << k)) begin
                r.size   = HSIZE_BYTE;
                r.offset = 3'(k);
            end
        end
        for (int k = 0; k < 8; k += 2) begin
            if (k < nbytes && be == (8'h03 << k)) begin
                r.size   = HSIZE_HALF;
                r.offset = 3'(k);
            end
        end
        if (nbytes == 8) begin
            for (int k = 0; k < 8; k += 4) begin
                if (be == (8'h0F << k)) begin
                    r.size   = HSIZE_WORD;
                    r.offset = 3'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ibex_ahb_arbiter.sv
// Selects which core port drives the AHB address phase: fixed data priority
// or round-robin, with the choice frozen while a stalled request is on the bus.
module ibex_ahb_arbiter
    import ibex_ahb_pkg::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic instr_req_i,
    input  logic data_req_i,
    input  logic en_i,
    input  logic hready_i,
    input  logic hold_i,
    input  logic hold_sel_i,
    output logic sel_o,
    output logic valid_o,
    output logic gnt_o
);

    port_e ptr_q, ptr_d;
    port_e sel;

    always_comb begin
        if (hold_i) begin
            sel = port_e'(hold_sel_i);
        end else if (instr_req_i && data_req_i) begin
            sel = (ARB_MODE == 1) ? ptr_q : PORT_DATA;
        end else if (data_req_i) begin
            sel = PORT_DATA;
        end else begin
            sel = PORT_INSTR;
        end
    end

    assign valid_o = en_i & ((sel == PORT_DATA) ? data_req_i : instr_req_i);
    assign gnt_o   = valid_o & hready_i;
    assign sel_o   = sel;

    // ptr_q names the port that wins the next contention.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o) begin
            ptr_d = (sel == PORT_DATA) ? PORT_INSTR : PORT_DATA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PORT_DATA;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ibex_ahb_lite_master.sv
// Merges the Ibex instruction-fetch and LSU req/gnt/rvalid ports onto a single
// pipelined AHB-Lite master (address phase of N+1 overlaps data phase of N).
module ibex_ahb_lite_master
    import ibex_ahb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    output logic                instr_err_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_err_o,
    output logic [ADDR_W-1:0]   HADDR,
    output logic [1:0]          HTRANS,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [3:0]          HPROT,
    output logic                HWRITE,
    output logic [DATA_W-1:0]   HWDATA,
    input  logic [DATA_W-1:0]   HRDATA,
    input  logic                HREADY,
    input  logic                HRESP
);

    localparam int         BE_W      = DATA_W / 8;
    localparam int         OFF_W     = $clog2(BE_W);
    localparam logic [2:0] FULL_SIZE = (DATA_W == 64) ? HSIZE_DWORD : HSIZE_WORD;

    logic              rst_q;
    logic              dphase_q, dphase_d;
    logic              owner_q, owner_d;
    logic              hold_q, hold_d;
    logic              hold_sel_q, hold_sel_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;

    logic      sel, addr_valid, gnt, addr_en, err_first, dphase_done;
    size_off_t be_dec;
    logic      unused_bits;

    // No new address phase during reset, the cycle after it, or the first
    // cycle of an error response.
    assign err_first = HRESP & ~HREADY;
    assign addr_en   = ~HRESET & ~rst_q & ~err_first;

    ibex_ahb_arbiter #(
        .ARB_MODE (ARB_MODE)
    ) u_arbiter (
        .clk_i       (HCLK),
        .rst_i       (HRESET),
        .instr_req_i (instr_req_i),
        .data_req_i  (data_req_i),
        .en_i        (addr_en),
        .hready_i    (HREADY),
        .hold_i      (hold_q),
        .hold_sel_i  (hold_sel_q),
        .sel_o       (sel),
        .valid_o     (addr_valid),
        .gnt_o       (gnt)
    );

    assign be_dec = be_to_size(8'(data_be_i), BE_W);

    always_comb begin
        HTRANS = HTRANS_IDLE;
        HADDR  = '0;
        HSIZE  = HSIZE_BYTE;
        HWRITE = 1'b0;
        HPROT  = 4'b0000;
        if (addr_valid) begin
            HTRANS = HTRANS_NONSEQ;
            if (sel == PORT_DATA) begin
                HADDR  = {data_addr_i[ADDR_W-1:OFF_W], be_dec.offset[OFF_W-1:0]};
                HSIZE  = be_dec.size;
                HWRITE = data_we_i;
                HPROT  = HPROT_DATA;
            end else begin
                HADDR  = {instr_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                HSIZE  = FULL_SIZE;
                HPROT  = HPROT_FETCH;
            end
        end
    end

    assign HBURST      = HBURST_SINGLE;
    assign HWDATA      = hwdata_q;
    assign instr_gnt_o = gnt & (sel == PORT_INSTR);
    assign data_gnt_o  = gnt & (sel == PORT_DATA);

    assign dphase_done    = dphase_q & HREADY & ~HRESET;
    assign instr_rvalid_o = dphase_done & (owner_q == PORT_INSTR);
    assign data_rvalid_o  = dphase_done & (owner_q == PORT_DATA);
    assign instr_err_o    = instr_rvalid_o & HRESP;
    assign data_err_o     = data_rvalid_o & HRESP;
    assign instr_rdata_o  = HRDATA;
    assign data_rdata_o   = HRDATA;

    always_comb begin
        dphase_d   = dphase_q;
        owner_d    = owner_q;
        hwdata_d   = hwdata_q;
        hold_d     = addr_valid & ~HREADY;
        hold_sel_d = sel;
        if (dphase_done) begin
            dphase_d = 1'b0;
        end
        if (gnt) begin
            dphase_d = 1'b1;
            owner_d  = sel;
            if (sel == PORT_DATA && data_we_i) begin
                hwdata_d = data_wdata_i;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        rst_q <= HRESET;
        if (HRESET) begin
            dphase_q   <= 1'b0;
            owner_q    <= PORT_INSTR;
            hold_q     <= 1'b0;
            hold_sel_q <= PORT_INSTR;
            hwdata_q   <= '0;
        end else begin
            dphase_q   <= dphase_d;
            owner_q    <= owner_d;
            hold_q     <= hold_d;
            hold_sel_q <= hold_sel_d;
            hwdata_q   <= hwdata_d;
        end
    end

    assign unused_bits = ^{instr_addr_i[OFF_W-1:0], data_addr_i[OFF_W-1:0], be_dec.offset};

endmodule

// File: tb/tb_ibex_ahb_lite_master.sv
// Directed and randomized checks of the dual-port AHB-Lite master; a second
// instance in round-robin mode shares the stimulus for the arbitration test.
module tb_ibex_ahb_lite_master;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESET;
    logic        instr_req_i, data_req_i, data_we_i;
    logic [31:0] instr_addr_i, data_addr_i, data_wdata_i, HRDATA;
    logic [3:0]  data_be_i;
    logic        HREADY, HRESP;

    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] instr_rdata_o, data_rdata_o, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HWRITE;

    logic        u1_instr_gnt, u1_instr_rvalid, u1_instr_err;
    logic        u1_data_gnt, u1_data_rvalid, u1_data_err;
    logic [31:0] u1_instr_rdata, u1_data_rdata, u1_haddr, u1_hwdata;
    logic [1:0]  u1_htrans;
    logic [2:0]  u1_hsize, u1_hburst;
    logic [3:0]  u1_hprot;
    logic        u1_hwrite;

    ibex_ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    ibex_ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) dut_rr (
        .HCLK(HCLK), .HRESET(HRESET),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(u1_instr_gnt),
        .instr_rvalid_o(u1_instr_rvalid), .instr_rdata_o(u1_instr_rdata), .instr_err_o(u1_instr_err),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(u1_data_gnt),
        .data_rvalid_o(u1_data_rvalid), .data_rdata_o(u1_data_rdata), .data_err_o(u1_data_err),
        .HADDR(u1_haddr), .HTRANS(u1_htrans), .HSIZE(u1_hsize), .HBURST(u1_hburst), .HPROT(u1_hprot),
        .HWRITE(u1_hwrite), .HWDATA(u1_hwdata), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    // Reference size rule: count enabled lanes, locate the lowest one.
    function automatic void ref_size(input logic [3:0] be, output logic [2:0] sz, output logic [1:0] off);
        int ones, lo;
        ones = $countones(be);
        lo   = 0;
        while (lo < 3 && be[lo] == 1'b0) lo++;
        if (ones == 1) begin
            sz = 3'd0; off = 2'(lo);
        end else if (be == 4'b0011 || be == 4'b1100) begin
            sz = 3'd1; off = 2'(lo);
        end else begin
            sz = 3'd2; off = 2'd0;
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        bit          i_pend, d_pend, have, port, e_gnt;
        bit          m_dp, m_dp_port, m_hold, m_hold_port;
        logic [31:0] m_wdata;
        logic [2:0]  e_sz;
        logic [1:0]  e_off;

        HRESET = 1'b1; instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0;
        data_be_i = 0; data_addr_i = 0; data_wdata_i = 0; HRDATA = 0; HREADY = 1; HRESP = 0;

        // Reset state
        next_cyc(); next_cyc();
        instr_req_i = 1; instr_addr_i = 32'h40;
        mid();
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hsize_hwrite", {HSIZE, HWRITE}, 4'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_gnt_rvalid_err", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                                   instr_err_o, data_err_o}, 6'b0);
        chk("rst_hburst", HBURST, 3'b000);
        next_cyc();
        HRESET = 1'b0; instr_req_i = 0;
        next_cyc();

        // Contention, both requests held for four cycles
        instr_req_i = 1; instr_addr_i = 32'h1000;
        data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("arb_fixed_dgnt", data_gnt_o, 1'b1);
            chk("arb_fixed_ignt", instr_gnt_o, 1'b0);
            chk("arb_rr_dgnt", u1_data_gnt, (k % 2 == 0));
            chk("arb_rr_ignt", u1_instr_gnt, (k % 2 == 1));
            if (k > 0) chk("arb_fixed_pipelined_rvalid", data_rvalid_o, 1'b1);
            next_cyc();
        end
        instr_req_i = 0; data_req_i = 0;
        mid();
        chk("arb_fixed_last_rvalid", data_rvalid_o, 1'b1);
        chk("arb_rr_last_irvalid", u1_instr_rvalid, 1'b1);
        chk("arb_idle_htrans", HTRANS, 2'b00);
        next_cyc();

        // Word write
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b1111; data_addr_i = 32'h100;
        data_wdata_i = 32'hDEADBEEF;
        mid();
        chk("wr_gnt", data_gnt_o, 1'b1);
        chk("wr_htrans", HTRANS, 2'b10);
        chk("wr_hsize", HSIZE, 3'd2);
        chk("wr_hwrite", HWRITE, 1'b1);
        chk("wr_haddr", HADDR, 32'h100);
        chk("wr_hprot", HPROT, 4'b0011);
        next_cyc();
        data_req_i = 0; data_we_i = 0; data_wdata_i = 0;
        mid();
        chk("wr_hwdata", HWDATA, 32'hDEADBEEF);
        chk("wr_rvalid", data_rvalid_o, 1'b1);
        chk("wr_err", data_err_o, 1'b0);
        next_cyc();

        // Byte read
        data_req_i = 1; data_be_i = 4'b0100; data_addr_i = 32'h200; HRDATA = 32'h00AB0000;
        mid();
        chk("byte_gnt", data_gnt_o, 1'b1);
        chk("byte_haddr", HADDR, 32'h202);
        chk("byte_hsize", HSIZE, 3'd0);
        chk("byte_hwrite", HWRITE, 1'b0);
        next_cyc();
        data_req_i = 0;
        mid();
        chk("byte_rvalid", data_rvalid_o, 1'b1);
        chk("byte_rdata", data_rdata_o, 32'h00AB0000);
        chk("byte_irvalid", instr_rvalid_o, 1'b0);
        chk("byte_hwdata_held", HWDATA, 32'hDEADBEEF);
        next_cyc();

        // Wait states during a read data phase with a stalled fetch on the bus
        data_req_i = 1; data_be_i = 4'hF; data_addr_i = 32'h300;
        mid();
        chk("ws_gnt", data_gnt_o, 1'b1);
        next_cyc();
        data_req_i = 0; instr_req_i = 1; instr_addr_i = 32'h400; HREADY = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin data_req_i = 1; data_addr_i = 32'h500; end
            mid();
            chk("ws_htrans", HTRANS, 2'b10);
            chk("ws_haddr", HADDR, 32'h400);
            chk("ws_hsize_hwrite", {HSIZE, HWRITE}, {3'd2, 1'b0});
            chk("ws_hprot", HPROT, 4'b0010);
            chk("ws_hwdata", HWDATA, 32'hDEADBEEF);
            chk("ws_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
            chk("ws_no_gnt", {instr_gnt_o, data_gnt_o}, 2'b00);
            next_cyc();
        end
        HREADY = 1; HRDATA = 32'h12345678;
        mid();
        chk("ws_drvalid", data_rvalid_o, 1'b1);
        chk("ws_rdata", data_rdata_o, 32'h12345678);
        chk("ws_held_ignt", instr_gnt_o, 1'b1);
        chk("ws_held_dgnt", data_gnt_o, 1'b0);
        chk("ws_held_haddr", HADDR, 32'h400);
        next_cyc();
        instr_req_i = 0;
        mid();
        chk("ws_irvalid", instr_rvalid_o, 1'b1);
        chk("ws_drvalid_once", data_rvalid_o, 1'b0);
        chk("ws_dgnt_after", data_gnt_o, 1'b1);
        chk("ws_haddr_after", HADDR, 32'h500);
        next_cyc();
        data_req_i = 0;
        mid();
        chk("ws_drvalid_after", data_rvalid_o, 1'b1);
        next_cyc();

        // Two-cycle error response with a fetch pending
        HRDATA = 0; data_req_i = 1; data_be_i = 4'hF; data_addr_i = 32'h600;
        mid();
        chk("err_gnt", data_gnt_o, 1'b1);
        next_cyc();
        data_req_i = 0; instr_req_i = 1; instr_addr_i = 32'h700; HRESP = 1; HREADY = 0;
        mid();
        chk("err1_htrans", HTRANS, 2'b00);
        chk("err1_ignt", instr_gnt_o, 1'b0);
        chk("err1_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b00);
        next_cyc();
        HREADY = 1;
        mid();
        chk("err2_drvalid_err", {data_rvalid_o, data_err_o}, 2'b11);
        chk("err2_irvalid", instr_rvalid_o, 1'b0);
        chk("err2_pending_ignt", instr_gnt_o, 1'b1);
        chk("err2_htrans", HTRANS, 2'b10);
        next_cyc();
        HRESP = 0; instr_req_i = 0;
        mid();
        chk("err3_irvalid_err", {instr_rvalid_o, instr_err_o}, 2'b10);
        chk("err3_drvalid", data_rvalid_o, 1'b0);
        next_cyc();

        // Reset in the middle of a read data phase
        data_req_i = 1; data_be_i = 4'hF; data_addr_i = 32'h800;
        mid();
        chk("mrst_gnt", data_gnt_o, 1'b1);
        next_cyc();
        data_req_i = 0; HRESET = 1;
        mid();
        chk("mrst_no_rvalid", data_rvalid_o, 1'b0);
        next_cyc();
        HRESET = 0; data_req_i = 1; data_addr_i = 32'h900;
        mid();
        chk("mrst_htrans_idle", HTRANS, 2'b00);
        chk("mrst_no_rvalid2", data_rvalid_o, 1'b0);
        chk("mrst_no_gnt", data_gnt_o, 1'b0);
        chk("mrst_hwdata", HWDATA, 32'h0);
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            next_cyc();
            mid();
            if (data_gnt_o === 1'b1) got = 1;
        end
        chk("mrst_regnt_seen", got, 1'b1);
        chk("mrst_regnt_haddr", HADDR, 32'h900);
        next_cyc();
        data_req_i = 0;
        mid();
        chk("mrst_rvalid_after", data_rvalid_o, 1'b1);
        next_cyc();

        // Randomized traffic against the reference model (fixed priority)
        m_dp = 0; m_dp_port = 0; m_hold = 0; m_hold_port = 0; m_wdata = 32'h0;
        i_pend = 0; d_pend = 0;
        for (int c = 0; c < 400; c++) begin
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1;
                instr_addr_i = $urandom() & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1;
                data_we_i    = 1'($urandom_range(0, 1));
                data_be_i    = 4'($urandom_range(0, 15));
                data_addr_i  = $urandom() & 32'hFFFF_FFFC;
                data_wdata_i = $urandom();
            end
            instr_req_i = i_pend;
            data_req_i  = d_pend;
            HREADY = ($urandom_range(0, 3) != 0);
            HRDATA = $urandom();
            mid();

            have  = i_pend || d_pend;
            port  = m_hold ? m_hold_port : d_pend;
            e_gnt = have && HREADY;
            chk("rnd_htrans", HTRANS, have ? 2'b10 : 2'b00);
            chk("rnd_gnt", {instr_gnt_o, data_gnt_o}, {e_gnt && !port, e_gnt && port});
            chk("rnd_rvalid", {instr_rvalid_o, data_rvalid_o},
                {m_dp && HREADY && !m_dp_port, m_dp && HREADY && m_dp_port});
            chk("rnd_hwdata", HWDATA, m_wdata);
            if (m_dp && HREADY)
                chk("rnd_rdata", m_dp_port ? data_rdata_o : instr_rdata_o, HRDATA);
            if (have && port) begin
                ref_size(data_be_i, e_sz, e_off);
                chk("rnd_d_addr", HADDR, {data_addr_i[31:2], e_off});
                chk("rnd_d_ctrl", {HSIZE, HWRITE, HPROT}, {e_sz, data_we_i, 4'b0011});
            end else if (have) begin
                chk("rnd_i_addr", HADDR, instr_addr_i);
                chk("rnd_i_ctrl", {HSIZE, HWRITE, HPROT}, {3'd2, 1'b0, 4'b0010});
            end

            if (m_dp && HREADY) m_dp = 0;
            if (e_gnt) begin
                m_dp = 1;
                m_dp_port = port;
                if (port && data_we_i) m_wdata = data_wdata_i;
                if (port) d_pend = 0;
                else i_pend = 0;
            end
            m_hold      = have && !HREADY;
            m_hold_port = port;
            next_cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
